// File: rtl/pack_framer.sv
// Double-buffered payload packer: collects input words into two banks and
// serialises preamble + payload frames, filling idle frames when no bank is ready.
module pack_framer #(
    parameter int                        SIZE_BIT_PACK   = 1976,
    parameter int                        SIZE_INPUT_BIT  = 8,
    parameter int                        SIZE_OUTPUT_BIT = 1,
    parameter int                        SIZE_PREAMBLE   = 32,
    parameter logic [SIZE_PREAMBLE-1:0]  PREAMBLE        = 32'h1ACFFC1D,
    parameter logic [SIZE_INPUT_BIT-1:0] IDLE_WORD       = 8'h55
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]  i_data,
    input  logic                       i_valid_input,
    output logic                       o_ready,
    input  logic                       i_flush,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready_output,
    output logic                       o_frame_start,
    output logic                       o_frame_last,
    output logic                       o_idle,
    output logic [15:0]                o_frame_cnt,
    output logic [15:0]                o_idle_cnt
);
    // state   | meaning
    // S_START | after reset, no frame presented yet
    // S_SEND  | a frame beat is presented on o_data
    typedef enum logic {S_START = 1'b0, S_SEND = 1'b1} state_t;

    localparam int P  = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_INPUT_BIT;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int OW = $clog2(SIZE_BIT_PACK);
    localparam int BW = (SIZE_INPUT_BIT > 1) ? $clog2(SIZE_INPUT_BIT) : 1;
    localparam logic [OW-1:0] LAST_OFF = OW'(SIZE_BIT_PACK - SIZE_OUTPUT_BIT);
    localparam logic [OW-1:0] PRE_OFF  = OW'(SIZE_PREAMBLE);
    localparam logic [OW-1:0] OB_OFF   = OW'(SIZE_OUTPUT_BIT);
    localparam logic [OW-1:0] IW_OFF   = OW'(SIZE_INPUT_BIT);
    localparam logic [PW-1:0] LAST_IDX = PW'(P - 1);

    logic [SIZE_INPUT_BIT-1:0] mem_q [0:1][0:P-1];

    state_t        state_q, state_d;
    logic [1:0]    full_q, full_d;
    logic          fill_bank_q, fill_bank_d;
    logic [PW-1:0] fill_idx_q, fill_idx_d;
    logic          tx_bank_q, tx_bank_d;
    logic          tx_idle_q, tx_idle_d;
    logic [OW-1:0] off_q, off_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   idle_cnt_q, idle_cnt_d;

    logic ready_int, accept, beat_acc, frame_end, sending;

    assign sending   = (state_q == S_SEND);
    assign ready_int = !full_q[fill_bank_q];
    assign accept    = i_valid_input && ready_int;
    assign beat_acc  = sending && i_ready_output;
    assign frame_end = beat_acc && (off_q == LAST_OFF);

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        fill_bank_d = fill_bank_q;
        fill_idx_d  = fill_idx_q;
        tx_bank_d   = tx_bank_q;
        tx_idle_d   = tx_idle_q;
        off_d       = off_q;
        frame_cnt_d = frame_cnt_q;
        idle_cnt_d  = idle_cnt_q;

        if (i_flush) begin
            fill_idx_d = '0;
        end else if (accept) begin
            if (fill_idx_q == LAST_IDX) begin
                full_d[fill_bank_q] = 1'b1;
                fill_idx_d          = '0;
                fill_bank_d         = ~fill_bank_q;
            end else begin
                fill_idx_d = fill_idx_q + 1'b1;
            end
        end

        if (beat_acc) begin
            off_d = off_q + OB_OFF;
        end
        if (frame_end) begin
            if (tx_idle_q) begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end else begin
                frame_cnt_d       = frame_cnt_q + 16'd1;
                full_d[tx_bank_q] = 1'b0;
            end
        end

        // The fill bank pointer always trails onto the older full bank when both are full.
        if (!sending || frame_end) begin
            state_d   = S_SEND;
            off_d     = '0;
            tx_idle_d = !(|full_d);
            tx_bank_d = full_d[fill_bank_d] ? fill_bank_d : ~fill_bank_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_START;
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            fill_idx_q  <= '0;
            tx_bank_q   <= 1'b0;
            tx_idle_q   <= 1'b0;
            off_q       <= '0;
            frame_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            fill_bank_q <= fill_bank_d;
            fill_idx_q  <= fill_idx_d;
            tx_bank_q   <= tx_bank_d;
            tx_idle_q   <= tx_idle_d;
            off_q       <= off_d;
            frame_cnt_q <= frame_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && accept && !i_flush) begin
            mem_q[fill_bank_q][fill_idx_q] <= i_data;
        end
    end

    logic [SIZE_PREAMBLE-1:0]   pre_sh;
    logic [SIZE_INPUT_BIT-1:0]  word, w_sh;
    logic [OW-1:0]              pay;
    logic [PW-1:0]              rd_idx;
    logic [BW-1:0]              rd_bit;
    logic [SIZE_OUTPUT_BIT-1:0] beat;

    always_comb begin
        pre_sh = PREAMBLE << off_q;
        word   = '0;
        w_sh   = '0;
        pay    = '0;
        rd_idx = '0;
        rd_bit = '0;
        beat   = '0;
        if (off_q < PRE_OFF) begin
            beat = pre_sh[SIZE_PREAMBLE-1 -: SIZE_OUTPUT_BIT];
        end else begin
            pay    = off_q - PRE_OFF;
            rd_idx = PW'(pay / IW_OFF);
            rd_bit = BW'(pay % IW_OFF);
            word   = tx_idle_q ? IDLE_WORD : mem_q[tx_bank_q][rd_idx];
            w_sh   = word << rd_bit;
            beat   = w_sh[SIZE_INPUT_BIT-1 -: SIZE_OUTPUT_BIT];
        end
    end

    assign o_ready       = ready_int;
    assign o_valid       = sending;
    assign o_data        = sending ? beat : '0;
    assign o_frame_start = sending && (off_q == '0);
    assign o_frame_last  = sending && (off_q == LAST_OFF);
    assign o_idle        = sending && tx_idle_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_idle_cnt    = idle_cnt_q;
endmodule
